// File: rtl/capture_sequencer_pkg.sv
// Shared types for the camera capture sequencer: the 3-bit state encoding
// (also exposed on state_out for debug) and a helper for the timeout window.
package capture_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE             = 3'd0,
        ST_WAKE             = 3'd1,
        ST_WAIT_FRAME_END   = 3'd2,
        ST_WAIT_FRAME_START = 3'd3,
        ST_CAPTURE          = 3'd4,
        ST_COMPRESS         = 3'd5,
        ST_READY            = 3'd6
    } state_t;

    // States in which the abort timer runs.
    function automatic logic is_timed(input state_t s);
        return (s == ST_WAIT_FRAME_END) || (s == ST_WAIT_FRAME_START) ||
               (s == ST_CAPTURE) || (s == ST_COMPRESS);
    endfunction

endpackage

// File: rtl/capture_cycle_timer.sv
// Saturating cycle counter with a runtime terminal-count compare; shared
// between the D-PHY wake delay and the capture abort timeout.
module capture_cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal_value,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

    assign terminal = (count == terminal_value);

endmodule

// File: rtl/capture_sequencer.sv
// Frame-aligned capture controller: wakes the D-PHY, waits for a whole frame,
// gates pixels to the encoder, waits for JPEG completion and flags the result.
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int WAKE_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 16777216
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       start_capture_in,
    input  logic       power_save_enable_in,
    input  logic       frame_valid_in,
    input  logic       jpeg_done_in,
    output logic       capture_enable_out,
    output logic       jpeg_reset_out,
    output logic       dphy_power_down_out,
    output logic       image_ready_out,
    output logic       busy_out,
    output logic       timeout_out,
    output logic [2:0] state_out
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > WAKE_CYCLES) ? TIMEOUT_CYCLES : WAKE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] WAKE_TERM    = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic             fv_q;
    logic             fv_rise;
    logic             fv_fall;
    logic             accept;
    logic             timed_out;
    logic             timer_clear;
    logic             timer_enable;
    logic             timer_terminal;
    logic [CNT_W-1:0] term_value;

    assign fv_rise = frame_valid_in & ~fv_q;
    assign fv_fall = ~frame_valid_in & fv_q;

    capture_cycle_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .clear         (timer_clear),
        .enable        (timer_enable),
        .terminal_value(term_value),
        .terminal      (timer_terminal)
    );

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        timed_out    = 1'b0;
        timer_clear  = 1'b0;
        timer_enable = is_timed(state);
        term_value   = TIMEOUT_TERM;
        case (state)
            ST_IDLE, ST_READY: begin
                if (start_capture_in) begin
                    accept      = 1'b1;
                    timer_clear = 1'b1;
                    state_next  = dphy_power_down_out ? ST_WAKE : ST_WAIT_FRAME_END;
                end
            end
            ST_WAKE: begin
                term_value   = WAKE_TERM;
                timer_enable = 1'b1;
                if (timer_terminal) begin
                    timer_clear = 1'b1;
                    state_next  = ST_WAIT_FRAME_END;
                end
            end
            ST_WAIT_FRAME_END: begin
                if (!frame_valid_in) state_next = ST_WAIT_FRAME_START;
            end
            ST_WAIT_FRAME_START: begin
                if (fv_rise) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (fv_fall) state_next = ST_COMPRESS;
            end
            ST_COMPRESS: begin
                if (jpeg_done_in) state_next = ST_READY;
            end
            default: state_next = ST_IDLE;
        endcase
        // A completion landing on the terminal count takes precedence over the abort.
        if (is_timed(state) && timer_terminal && (state_next != ST_READY)) begin
            timed_out  = 1'b1;
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state               <= ST_IDLE;
            fv_q                <= 1'b0;
            capture_enable_out  <= 1'b0;
            jpeg_reset_out      <= 1'b0;
            dphy_power_down_out <= 1'b0;
            image_ready_out     <= 1'b0;
            timeout_out         <= 1'b0;
        end else begin
            state              <= state_next;
            fv_q               <= frame_valid_in;
            jpeg_reset_out     <= accept;
            capture_enable_out <= (state_next == ST_CAPTURE);
            if (accept) begin
                image_ready_out <= 1'b0;
                timeout_out     <= 1'b0;
            end else begin
                if ((state == ST_COMPRESS) && (state_next == ST_READY)) image_ready_out <= 1'b1;
                if (timed_out) timeout_out <= 1'b1;
            end
            // Power-down only tracks the request while parked; otherwise the PHY stays up.
            if (((state == ST_IDLE) || (state == ST_READY)) && !accept) begin
                dphy_power_down_out <= power_save_enable_in;
            end else begin
                dphy_power_down_out <= 1'b0;
            end
        end
    end

    assign busy_out  = (state != ST_IDLE) && (state != ST_READY);
    assign state_out = state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer: output events are queued with their
// expected cycle when stimulus is driven and matched as the DUT produces them.
module tb_capture_sequencer;

    localparam int EV_JRST    = 1;
    localparam int EV_CAP_ON  = 2;
    localparam int EV_CAP_OFF = 3;
    localparam int EV_READY   = 4;
    localparam int EV_TIMEOUT = 5;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic       clock_in = 1'b0;
    logic       reset_in = 1'b1;
    logic       start_capture_in = 1'b0;
    logic       power_save_enable_in = 1'b0;
    logic       frame_valid_in = 1'b0;
    logic       jpeg_done_in = 1'b0;
    logic       capture_enable_out;
    logic       jpeg_reset_out;
    logic       dphy_power_down_out;
    logic       image_ready_out;
    logic       busy_out;
    logic       timeout_out;
    logic [2:0] state_out;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    int  mark;
    logic prev_cap = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_timeout = 1'b0;

    capture_sequencer #(
        .WAKE_CYCLES(8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clock_in            (clock_in),
        .reset_in            (reset_in),
        .start_capture_in    (start_capture_in),
        .power_save_enable_in(power_save_enable_in),
        .frame_valid_in      (frame_valid_in),
        .jpeg_done_in        (jpeg_done_in),
        .capture_enable_out  (capture_enable_out),
        .jpeg_reset_out      (jpeg_reset_out),
        .dphy_power_down_out (dphy_power_down_out),
        .image_ready_out     (image_ready_out),
        .busy_out            (busy_out),
        .timeout_out         (timeout_out),
        .state_out           (state_out)
    );

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic expect_event(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic match_event(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_event", kind, 0);
        end else begin
            e = exp_q.pop_front();
            checkOutput("event_kind", kind, e.kind);
            checkOutput("event_cycle", cyc, e.at);
        end
    endtask

    // Event monitor samples on the falling edge, clear of the active edge.
    always @(negedge clock_in) begin
        if (jpeg_reset_out === 1'b1) match_event(EV_JRST);
        if (capture_enable_out === 1'b1 && !prev_cap) match_event(EV_CAP_ON);
        if (capture_enable_out === 1'b0 && prev_cap) match_event(EV_CAP_OFF);
        if (image_ready_out === 1'b1 && !prev_ready) match_event(EV_READY);
        if (timeout_out === 1'b1 && !prev_timeout) match_event(EV_TIMEOUT);
        prev_cap     = (capture_enable_out === 1'b1);
        prev_ready   = (image_ready_out === 1'b1);
        prev_timeout = (timeout_out === 1'b1);
    end

    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clock_in);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic st, input logic fv, input logic jd, input int n);
        start_capture_in = st;
        frame_valid_in   = fv;
        jpeg_done_in     = jd;
        step(n);
    endtask

    task automatic start_capture();
        expect_event(EV_JRST, cyc + 1);
        applyStimulus(1'b1, frame_valid_in, 1'b0, 1);
        start_capture_in = 1'b0;
    endtask

    // Frame of 'active' cycles from WAIT_FRAME_START; optionally pokes a start mid-frame.
    task automatic capture_frame(input int active, input bit poke);
        expect_event(EV_CAP_ON, cyc + 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("cap_state", state_out, 4);
        if (poke) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1);
            applyStimulus(1'b0, 1'b1, 1'b0, active - 2);
        end else begin
            applyStimulus(1'b0, 1'b1, 1'b0, active - 1);
        end
        expect_event(EV_CAP_OFF, cyc + 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("compress_state", state_out, 5);
    endtask

    task automatic finish_jpeg(input int gap, input bit poke);
        if (poke) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1);
            applyStimulus(1'b0, 1'b0, 1'b0, gap - 1);
        end else begin
            applyStimulus(1'b0, 1'b0, 1'b0, gap);
        end
        expect_event(EV_READY, cyc + 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("ready_state", state_out, 6);
        checkOutput("ready_flag", image_ready_out, 1);
        checkOutput("ready_busy", busy_out, 0);
        checkOutput("ready_timeout", timeout_out, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish by cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        step(3);
        checkOutput("rst_state", state_out, 0);
        checkOutput("rst_busy", busy_out, 0);
        checkOutput("rst_cap", capture_enable_out, 0);
        checkOutput("rst_jrst", jpeg_reset_out, 0);
        checkOutput("rst_dphy", dphy_power_down_out, 0);
        checkOutput("rst_ready", image_ready_out, 0);
        checkOutput("rst_timeout", timeout_out, 0);
        reset_in = 1'b0;

        $display("[TB] jpeg_done outside COMPRESS");
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("idle_jd_ready", image_ready_out, 0);
        checkOutput("idle_jd_state", state_out, 0);

        $display("[TB] normal powered capture");
        start_capture();
        checkOutput("s1_wfe", state_out, 2);
        checkOutput("s1_busy", busy_out, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4);
        checkOutput("s1_hold_wfe", state_out, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        checkOutput("s1_wfs", state_out, 3);
        capture_frame(20, 1'b0);
        finish_jpeg(6, 1'b0);

        $display("[TB] power-save wake");
        power_save_enable_in = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        checkOutput("s2_dphy_down", dphy_power_down_out, 1);
        checkOutput("s2_ready_kept", image_ready_out, 1);
        power_save_enable_in = 1'b0;
        start_capture();
        checkOutput("s2_wake", state_out, 1);
        checkOutput("s2_dphy_up", dphy_power_down_out, 0);
        checkOutput("s2_ready_clr", image_ready_out, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 7);
        checkOutput("s2_wake_last", state_out, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("s2_wfe", state_out, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        capture_frame(4, 1'b0);
        finish_jpeg(2, 1'b0);

        $display("[TB] dropped starts");
        start_capture();
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        capture_frame(6, 1'b1);
        finish_jpeg(4, 1'b1);

        $display("[TB] timeout");
        start_capture();
        mark = cyc;
        expect_event(EV_TIMEOUT, mark + 64);
        applyStimulus(1'b0, 1'b0, 1'b0, 63);
        checkOutput("s3_pre_state", state_out, 3);
        checkOutput("s3_pre_timeout", timeout_out, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("s3_state", state_out, 0);
        checkOutput("s3_timeout", timeout_out, 1);
        checkOutput("s3_busy", busy_out, 0);
        checkOutput("s3_ready", image_ready_out, 0);

        $display("[TB] completion on terminal count");
        start_capture();
        mark = cyc;
        checkOutput("s5_timeout_clr", timeout_out, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        capture_frame(10, 1'b0);
        finish_jpeg(mark + 63 - cyc, 1'b0);
        start_capture();
        checkOutput("s5_restart_ready", image_ready_out, 0);
        checkOutput("s5_restart_jrst", jpeg_reset_out, 1);

        $display("[TB] reset during capture");
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        expect_event(EV_CAP_ON, cyc + 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 3);
        checkOutput("s6_capturing", capture_enable_out, 1);
        expect_event(EV_CAP_OFF, cyc + 1);
        reset_in = 1'b1;
        step(1);
        reset_in = 1'b0;
        checkOutput("s6_state", state_out, 0);
        checkOutput("s6_cap", capture_enable_out, 0);
        checkOutput("s6_jrst", jpeg_reset_out, 0);
        checkOutput("s6_busy", busy_out, 0);
        checkOutput("s6_dphy", dphy_power_down_out, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);

        $display("[TB] deferred power save");
        start_capture();
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        capture_frame(5, 1'b0);
        power_save_enable_in = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        checkOutput("s6_dphy_deferred", dphy_power_down_out, 0);
        finish_jpeg(0, 1'b0);
        checkOutput("s6_dphy_at_ready", dphy_power_down_out, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("s6_dphy_applied", dphy_power_down_out, 1);
        checkOutput("s6_ready_kept", image_ready_out, 1);

        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        checkOutput("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
